control_seq: RTL and testbench
==============================

// Module: control_seq
// PURPOSE
//  Instruction sequencer for the VeriRISC CPU. It drives the fetch/decode/execute ring that steers
//  the PC, IR, ALU-input accumulator load and memory strobes. Consumes the ALU zero flag and the
//  IR opcode (typedefs::opcode_t). Adds a mem_ready wait-state handshake, a wait timeout and a
//  sticky halt.
// PARAMETERS
//  MAX_WAIT   8   max consecutive cycles waiting for mem_ready before bus error (>=1)
//  CNT_WIDTH  16  width of retired-instruction counter
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  opcode     in   opcode_t   current IR opcode (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7)
//  zero       in   1          accumulator==0 flag from ALU
//  mem_ready  in   1          memory has completed current read/write access
//  mem_rd     out  1          memory read strobe
//  mem_wr     out  1          memory write strobe
//  load_ir    out  1          load instruction register
//  load_ac    out  1          load accumulator with ALU out
//  load_pc    out  1          load PC from IR operand (jump)
//  inc_pc     out  1          increment PC
//  halt       out  1          CPU halted (sticky)
//  bus_err    out  1          mem_ready timeout occurred (sticky)
//  phase      out  3          current state encoding (debug)
//  instr_cnt  out  CNT_WIDTH  instructions retired, saturating
// BEHAVIOUR
//  Clock and reset:
//  - Only clk is used; rst is asynchronous, active-high.
//  - While rst=1: state=INST_ADDR, halt=0, bus_err=0, instr_cnt=0, wait_cnt=0; all strobes 0.
//  State ring (phase encoding 0..7):
//    INST_ADDR > INST_FETCH > INST_LOAD > IDLE > OP_ADDR > OP_FETCH > ALU_OP > STORE > INST_ADDR
//  - Each state lasts 1 cycle, except the wait states below.
//  Wait states:
//  - INST_FETCH: advance only when mem_ready=1.
//  - OP_FETCH with ALUOP (ADD,AND,XOR,LDA): advance only when mem_ready=1; else 1 cycle.
//  - STORE with opcode=STO: advance only when mem_ready=1.
//  - wait_cnt counts consecutive stalled cycles and clears when the state advances.
//  - Stall cycle with wait_cnt==MAX_WAIT-1: set bus_err=1 and halt=1 next edge.
//  Strobes (Moore on state, qualified by opcode/zero; ALUOP as above):
//    INST_FETCH : mem_rd
//    INST_LOAD  : mem_rd, load_ir
//    IDLE       : mem_rd, load_ir
//    OP_ADDR    : inc_pc
//    OP_FETCH   : mem_rd=ALUOP
//    ALU_OP     : mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP)
//    STORE      : mem_rd=ALUOP, load_ac=ALUOP, load_pc=inc_pc=(opcode==JMP), mem_wr=(opcode==STO)
//  Halt:
//  - In OP_ADDR with opcode==HLT: halt=1 at next edge, no inc_pc in that cycle.
//  - Once halt=1: state frozen, all strobes 0, phase holds; only rst clears halt.
//  instr_cnt:
//  - +1 on each STORE->INST_ADDR transition; saturates at all-ones, no wrap.
//  - A halted (HLT) instruction is not counted.
//  Reset mid-instruction:
//  - Aborts immediately; strobes drop asynchronously with rst.
//  - Restarts at INST_ADDR on the first edge after release.
// TESTING
//  - Reset then LDA, mem_ready=1 always -> phases 0..7 in 8 cycles; load_ac=1 in ALU_OP and STORE;
//    instr_cnt=1.
//  - SKZ with zero=1 -> inc_pc=1 in OP_ADDR and ALU_OP (skip); with zero=0 -> only OP_ADDR inc_pc.
//  - STO with mem_ready low 3 cycles in STORE -> mem_wr held 4 cycles, then INST_ADDR;
//    bus_err=0 (MAX_WAIT=8).
//  - mem_ready stuck 0 in INST_FETCH -> bus_err=1, halt=1 after 8 stall cycles;
//    all strobes 0 thereafter.
//  - HLT -> halt=1 after OP_ADDR, phase stays 4, instr_cnt unchanged; rst pulse -> halt=0, phase=0.
//  - Force instr_cnt to all-ones (CNT_WIDTH=4, 16 JMPs) -> count stays 15;
//    rst asserted in ALU_OP clears outputs async.

Source files
------------

// File: rtl/typedefs.sv
// Shared VeriRISC types: instruction opcode encoding.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

endpackage

// File: rtl/control_seq.sv
// VeriRISC instruction sequencer: 8-phase fetch/decode/execute ring with
// mem_ready wait states, wait timeout (bus error), sticky halt and a
// saturating retired-instruction counter.
module control_seq
  import typedefs::*;
#(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  opcode_t              opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 load_ir,
  output logic                 load_ac,
  output logic                 load_pc,
  output logic                 inc_pc,
  output logic                 halt,
  output logic                 bus_err,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  state_t                r_state;
  logic                  r_halt;
  logic                  r_bus_err;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [CNT_WIDTH-1:0]  r_instr_cnt;

  state_t                w_state_nxt;
  logic                  w_halt_nxt;
  logic                  w_bus_err_nxt;
  logic [WAIT_W-1:0]     w_wait_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_stall;
  logic                  w_aluop;
  logic                  w_mem_rd;
  logic                  w_mem_wr;
  logic                  w_load_ir;
  logic                  w_load_ac;
  logic                  w_load_pc;
  logic                  w_inc_pc;

  // Opcodes that read an operand from memory and load the accumulator.
  assign w_aluop = (opcode == ADD) || (opcode == AND) ||
                   (opcode == XOR) || (opcode == LDA);

  // State, sticky flags, wait counter and retired counter; all cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INST_ADDR;
      r_halt      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_wait_cnt  <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_halt      <= w_halt_nxt;
      r_bus_err   <= w_bus_err_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_instr_cnt <= w_cnt_nxt;
    end
  end

  // Next-state, wait/halt handling and per-state strobe decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_halt_nxt    = r_halt;
    w_bus_err_nxt = r_bus_err;
    w_wait_nxt    = r_wait_cnt;
    w_cnt_nxt     = r_instr_cnt;
    w_stall       = 1'b0;
    w_mem_rd      = 1'b0;
    w_mem_wr      = 1'b0;
    w_load_ir     = 1'b0;
    w_load_ac     = 1'b0;
    w_load_pc     = 1'b0;
    w_inc_pc      = 1'b0;

    if (!r_halt) begin
      unique case (r_state)
        INST_ADDR: begin
          w_state_nxt = INST_FETCH;
        end
        INST_FETCH: begin
          w_mem_rd    = 1'b1;
          w_stall     = !mem_ready;
          w_state_nxt = INST_LOAD;
        end
        INST_LOAD: begin
          w_mem_rd    = 1'b1;
          w_load_ir   = 1'b1;
          w_state_nxt = IDLE;
        end
        IDLE: begin
          w_mem_rd    = 1'b1;
          w_load_ir   = 1'b1;
          w_state_nxt = OP_ADDR;
        end
        OP_ADDR: begin
          // HLT freezes here without advancing the PC.
          if (opcode == HLT) begin
            w_halt_nxt = 1'b1;
          end else begin
            w_inc_pc    = 1'b1;
            w_state_nxt = OP_FETCH;
          end
        end
        OP_FETCH: begin
          w_mem_rd    = w_aluop;
          w_stall     = w_aluop && !mem_ready;
          w_state_nxt = ALU_OP;
        end
        ALU_OP: begin
          w_mem_rd    = w_aluop;
          w_load_ac   = w_aluop;
          w_inc_pc    = (opcode == SKZ) && zero;
          w_load_pc   = (opcode == JMP);
          w_state_nxt = STORE;
        end
        STORE: begin
          w_mem_rd    = w_aluop;
          w_load_ac   = w_aluop;
          w_load_pc   = (opcode == JMP);
          w_inc_pc    = (opcode == JMP);
          w_mem_wr    = (opcode == STO);
          w_stall     = (opcode == STO) && !mem_ready;
          w_state_nxt = INST_ADDR;
        end
      endcase

      if (w_stall) begin
        // Hold the state; the last permitted stall raises bus error and halt.
        w_state_nxt = r_state;
        if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
          w_bus_err_nxt = 1'b1;
          w_halt_nxt    = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end else begin
        w_wait_nxt = '0;
        if ((r_state == STORE) && !(&r_instr_cnt)) begin
          w_cnt_nxt = r_instr_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign mem_rd    = w_mem_rd;
  assign mem_wr    = w_mem_wr;
  assign load_ir   = w_load_ir;
  assign load_ac   = w_load_ac;
  assign load_pc   = w_load_pc;
  assign inc_pc    = w_inc_pc;
  assign halt      = r_halt;
  assign bus_err   = r_bus_err;
  assign phase     = r_state;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: an expected per-cycle trace is built
// from the instruction-level rules and compared against the DUT each cycle.
module tb_control_seq;
  import typedefs::*;

  localparam int unsigned MW = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  opcode_t       opcode;
  logic          zero;
  logic          mem_ready;
  logic          mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc;
  logic          halt, bus_err;
  logic [2:0]    phase;
  logic [CW-1:0] instr_cnt;

  control_seq #(.MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .load_ac(load_ac),
    .load_pc(load_pc), .inc_pc(inc_pc), .halt(halt), .bus_err(bus_err),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: inputs to drive and outputs required in that cycle.
  typedef struct {
    bit         mr;
    opcode_t    op;
    bit         z;
    logic [2:0] ph;
    logic [5:0] s;   // {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc}
    bit         h;
    bit         b;
    logic [3:0] cnt;
  } cyc_t;

  cyc_t    plan[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc    = 0;
  bit      m_halt, m_berr;
  int      m_cnt;
  opcode_t cur_op;
  bit      cur_z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strb(bit rd, bit wr, bit ir, bit ac, bit pc, bit inc);
    return {rd, wr, ir, ac, pc, inc};
  endfunction

  function automatic logic [5:0] dut_strb();
    return {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc};
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic emit(input logic [2:0] ph, input bit mr, input logic [5:0] s);
    cyc_t c;
    c.mr = mr; c.op = cur_op; c.z = cur_z; c.ph = ph; c.s = s;
    c.h = m_halt; c.b = m_berr; c.cnt = 4'(m_cnt);
    plan.push_back(c);
  endtask

  // w cycles with mem_ready low, then one ready cycle; too many stalls halt.
  task automatic wait_pt(input logic [2:0] ph, input logic [5:0] s, input int w);
    for (int i = 0; i < w; i++) begin
      emit(ph, 1'b0, s);
      if (i == MW - 1) begin
        m_halt = 1'b1;
        m_berr = 1'b1;
        return;
      end
    end
    emit(ph, 1'b1, s);
  endtask

  task automatic frozen(input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) emit(ph, rnd(), 6'd0);
  endtask

  // Expected trace of one instruction from the sequencer's published rules.
  task automatic plan_instr(input opcode_t op, input bit z, input int w_if,
                            input int w_of, input int w_st);
    bit alu;
    logic [5:0] s7;
    cur_op = op;
    cur_z  = z;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    emit(3'd0, rnd(), 6'd0);
    wait_pt(3'd1, strb(1, 0, 0, 0, 0, 0), w_if);
    if (m_halt) return;
    emit(3'd2, rnd(), strb(1, 0, 1, 0, 0, 0));
    emit(3'd3, rnd(), strb(1, 0, 1, 0, 0, 0));
    if (op == HLT) begin
      emit(3'd4, rnd(), 6'd0);
      m_halt = 1'b1;
      return;
    end
    emit(3'd4, rnd(), strb(0, 0, 0, 0, 0, 1));
    if (alu) wait_pt(3'd5, strb(1, 0, 0, 0, 0, 0), w_of);
    else     emit(3'd5, rnd(), 6'd0);
    if (m_halt) return;
    emit(3'd6, rnd(), strb(alu, 0, 0, alu, op == JMP, (op == SKZ) && z));
    s7 = strb(alu, op == STO, 0, alu, op == JMP, op == JMP);
    if (op == STO) wait_pt(3'd7, s7, w_st);
    else           emit(3'd7, rnd(), s7);
    if (m_halt) return;
    if (m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic check_rec(input cyc_t c);
    check($sformatf("phase@%0d", cyc), 32'(phase), 32'(c.ph));
    check($sformatf("strobes@%0d", cyc), 32'(dut_strb()), 32'(c.s));
    check($sformatf("halt@%0d", cyc), 32'(halt), 32'(c.h));
    check($sformatf("bus_err@%0d", cyc), 32'(bus_err), 32'(c.b));
    check($sformatf("instr_cnt@%0d", cyc), 32'(instr_cnt), 32'(c.cnt));
  endtask

  // Drive one planned cycle, sample mid-cycle, advance to just past the edge.
  task automatic step(input cyc_t c);
    opcode    = c.op;
    zero      = c.z;
    mem_ready = c.mr;
    @(negedge clk);
    check_rec(c);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(plan.pop_front());
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_strobes"}, 32'(dut_strb()), 32'd0);
    check({tag, "_halt"}, 32'(halt), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    check({tag, "_cnt"}, 32'(instr_cnt), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    opcode    = opcode_t'($urandom_range(0, 7));
    mem_ready = rnd();
    zero      = rnd();
    #2;
    check_cleared(tag);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_halt = 1'b0;
    m_berr = 1'b0;
    m_cnt  = 0;
    plan.delete();
  endtask

  initial begin
    cyc_t c;
    rst = 1'b1; opcode = HLT; zero = 1'b0; mem_ready = 1'b0;
    m_halt = 1'b0; m_berr = 1'b0; m_cnt = 0;
    #12;

    // Directed: full ring, skip taken/not taken, store wait, max legal wait.
    do_reset("rst0");
    plan_instr(LDA, 1'b0, 0, 0, 0);
    plan_instr(SKZ, 1'b1, 0, 0, 0);
    plan_instr(SKZ, 1'b0, 0, 0, 0);
    plan_instr(STO, 1'b0, 0, 0, 3);
    plan_instr(ADD, 1'b1, 2, MW - 1, 0);
    plan_instr(STO, 1'b1, MW - 1, 0, MW - 1);
    run_n(plan.size());

    // Random instruction mix with random legal wait lengths.
    for (int i = 0; i < 24; i++) begin
      plan_instr(opcode_t'($urandom_range(1, 7)), rnd(),
                 $urandom_range(0, MW - 1), $urandom_range(0, MW - 1),
                 $urandom_range(0, MW - 1));
    end
    run_n(plan.size());

    // Timeout in INST_FETCH: freezes with bus error and halt.
    do_reset("rst1");
    plan_instr(LDA, 1'b0, MW, 0, 0);
    frozen(3'd1, 5);
    run_n(plan.size());

    // Timeout on a store wait.
    do_reset("rst2");
    plan_instr(XOR, 1'b0, 0, 1, 0);
    plan_instr(STO, 1'b0, 0, 0, MW + 2);
    frozen(3'd7, 4);
    run_n(plan.size());

    // HLT after one retired instruction; count stays, phase holds at 4.
    do_reset("rst3");
    plan_instr(AND, 1'b0, 1, 1, 0);
    plan_instr(HLT, 1'b0, 0, 0, 0);
    frozen(3'd4, 6);
    run_n(plan.size());
    do_reset("rst4");

    // Saturation with 16 JMPs, then async reset in ALU_OP of the next LDA.
    for (int i = 0; i < 16; i++) plan_instr(JMP, rnd(), 0, 0, 0);
    plan_instr(LDA, 1'b0, 0, 0, 0);
    run_n(plan.size() - 2);
    c = plan.pop_front();
    opcode = c.op; zero = c.z; mem_ready = c.mr;
    @(negedge clk);
    check_rec(c);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_halt = 1'b0; m_berr = 1'b0; m_cnt = 0;
    plan.delete();
    plan_instr(LDA, 1'b1, 1, 0, 0);
    run_n(plan.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
